// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the fetch/data memory arbiter.
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RESP} state_t;
    typedef enum logic {OWN_IF, OWN_D} owner_t;
    localparam int STREAK_W = 4;
endpackage

// File: rtl/mem_arb_prio.sv
// mem_arb_prio: picks fetch or data each arbitration and tracks how long fetch has been starved.
module mem_arb_prio
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   arb_en,
    input  logic   if_req,
    input  logic   if_kill,
    input  logic   d_req,
    output logic   win_vld,
    output owner_t win_owner
);
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic if_vld, starved;

    always_comb begin
        if_vld    = if_req && !if_kill;
        starved   = streak_q == STREAK_W'(STARVE_MAX);
        win_vld   = if_vld || d_req;
        win_owner = (d_req && !(if_vld && starved)) ? OWN_D : OWN_IF;
        streak_d  = streak_q;
        // Streak only grows while a fetch is actually waiting behind data.
        if (arb_en && win_vld)
            streak_d = (win_owner == OWN_IF || !if_req) ? '0 : (starved ? streak_q : streak_q + 1'b1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) streak_q <= '0;
        else      streak_q <= streak_d;
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between fetch and data stages, one transaction at a time.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                if_kill,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_stall,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_stall,
    output logic                m_req,
    output logic                m_we,
    output logic [DATA_W/8-1:0] m_be,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    input  logic                m_gnt,
    input  logic                m_rvalid,
    input  logic [DATA_W-1:0]   m_rdata,
    output logic                busy,
    output logic                err
);
    state_t state_q, state_d;
    owner_t owner_q, owner_d, win_owner;
    logic kill_q, kill_d, m_req_q, m_req_d, m_we_q, m_we_d, err_q, err_d;
    logic [DATA_W/8-1:0] m_be_q, m_be_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
    logic win_vld, if_own, resp;

    mem_arb_prio #(.STARVE_MAX(STARVE_MAX)) u_prio (
        .clk       (clk),
        .rst       (rst),
        .arb_en    (state_q == IDLE),
        .if_req    (if_req),
        .if_kill   (if_kill),
        .d_req     (d_req),
        .win_vld   (win_vld),
        .win_owner (win_owner)
    );

    assign if_own    = owner_q == OWN_IF;
    assign resp      = state_q == WAIT_RESP && m_rvalid;
    // A kill arriving with the response still discards it; the fetch is already dead.
    assign if_rvalid = resp && if_own && !kill_q && !if_kill;
    assign d_rvalid  = resp && !if_own;
    assign if_rdata  = m_rdata;
    assign d_rdata   = m_rdata;
    assign if_stall  = if_req && !if_rvalid;
    assign d_stall   = d_req && !d_rvalid;
    assign busy      = state_q != IDLE;
    assign err       = err_q;
    assign m_req     = m_req_q;
    assign m_we      = m_we_q;
    assign m_be      = m_be_q;
    assign m_addr    = m_addr_q;
    assign m_wdata   = m_wdata_q;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        kill_d    = kill_q;
        m_req_d   = m_req_q;
        m_we_d    = m_we_q;
        m_be_d    = m_be_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        err_d     = err_q || (m_rvalid && state_q != WAIT_RESP);
        unique case (state_q)
            IDLE: if (win_vld) begin
                state_d   = WAIT_GNT;
                owner_d   = win_owner;
                kill_d    = 1'b0;
                m_req_d   = 1'b1;
                m_we_d    = win_owner == OWN_D && d_we;
                m_be_d    = win_owner == OWN_D ? d_be : '1;
                m_addr_d  = win_owner == OWN_D ? d_addr : if_addr;
                m_wdata_d = win_owner == OWN_D ? d_wdata : '0;
            end
            WAIT_GNT: if (m_gnt) begin
                state_d = WAIT_RESP;
                m_req_d = 1'b0;
                kill_d  = if_kill && if_own;
            end else if (if_kill && if_own) begin
                state_d = IDLE;
                m_req_d = 1'b0;
            end
            WAIT_RESP: begin
                kill_d = kill_q || (if_kill && if_own);
                if (m_rvalid) begin
                    state_d = IDLE;
                    kill_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            owner_q   <= OWN_IF;
            kill_q    <= 1'b0;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_be_q    <= '0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            kill_q    <= kill_d;
            m_req_q   <= m_req_d;
            m_we_q    <= m_we_d;
            m_be_q    <= m_be_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            err_q     <= err_d;
        end
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

- Shares one single-port instruction/data memory between the fetch stage and the memory stage of the 5-stage RISC-V pipeline.
- Arbitrates the two requesters, sequences one memory transaction at a time through a small FSM, and routes the response back to its owner.
- Produces per-port stall signals for hazard detection, cancels killed fetches, and raises a sticky protocol error that feeds the processor `err` output.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `STARVE_MAX`, 4, consecutive data grants allowed while fetch waits (range 1..15)
- `clk`  in  1  clock
- `rst`  in  1  asynchronous, active-low reset
- `if_req`  in  1  fetch read request; held with `if_addr` until `if_rvalid`
- `if_addr`  in  ADDR_W  fetch address
- `if_kill`  in  1  fetch cancelled (taken branch/jump/interrupt); one-cycle pulse
- `if_rvalid`  out  1  fetch data valid, one-cycle pulse
- `if_rdata`  out  DATA_W  fetch data
- `if_stall`  out  1  `if_req && !if_rvalid`
- `d_req`  in  1  data request; held with its payload until `d_rvalid`
- `d_we`  in  1  1 = store
- `d_be`  in  DATA_W/8  byte enables
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  store data
- `d_rvalid`  out  1  data done (load data or store ack), one-cycle pulse
- `d_rdata`  out  DATA_W  load data
- `d_stall`  out  1  `d_req && !d_rvalid`
- `m_req`  out  1  memory request
- `m_we`, `m_be`, `m_addr`, `m_wdata`  out  1 / DATA_W/8 / ADDR_W / DATA_W  memory request payload
- `m_gnt`  in  1  memory accepted request this cycle
- `m_rvalid`  in  1  memory response (reads and writes), arrives at least one cycle after `m_gnt`
- `m_rdata`  in  DATA_W  memory read data
- `busy`  out  1  state != IDLE
- `err`  out  1  sticky protocol error

## Operation
- States: IDLE, WAIT_GNT, WAIT_RESP.
- **IDLE:** if any request is pending, latch the winner's payload into holding registers, record the owner, and go to WAIT_GNT.
  - Winner is data, unless `if_req && streak == STARVE_MAX`, in which case fetch wins.
  - Fetch wins if only fetch requests.
  - A fetch with `if_kill` asserted in the same cycle is not latched.
- **WAIT_GNT:** `m_req` = 1 and the payload comes from the holding registers, stable until `m_gnt`.
  - `m_gnt` → WAIT_RESP.
  - `if_kill` with owner = fetch and no `m_gnt` → drop `m_req` and return to IDLE.
  - `if_kill` with `m_gnt` in the same cycle → WAIT_RESP with the kill flag set.
- **WAIT_RESP:** on `m_rvalid`, return to IDLE.
  - Pulse the owner's `rvalid` with `m_rdata`, unless the owner is fetch and the kill flag is set, in which case the response is discarded silently.
  - `if_kill` while in WAIT_RESP with owner = fetch sets the kill flag.
- **Streak counter** (4 bits):
  - Incremented on each data latch while `if_req` is high; saturates at STARVE_MAX.
  - Cleared on any fetch latch, and on a data latch when `if_req` is low.
- **Protocol errors:** `m_rvalid` in IDLE or WAIT_GNT is ignored and sets `err`. `err` is cleared only by reset.
- `if_kill` while the owner is data has no effect on the data transaction.

## Timing
- All outputs are registered except `if_stall`, `d_stall`, `if_rdata`/`d_rdata` (= `m_rdata`), and `if_rvalid`/`d_rvalid` (decoded from `m_rvalid`, owner and kill flag).
- Reset (async assert, sync deassert is the system's job): state IDLE, `m_req`/`m_we`/`m_be`/`m_addr`/`m_wdata` = 0, `busy` = 0, `err` = 0, streak = 0, kill flag = 0.
  - Reset mid-transaction abandons the transaction.
  - A late `m_rvalid` after reset sets `err`.
- Latency with a zero-wait memory (`m_gnt` in the first WAIT_GNT cycle, `m_rvalid` one cycle later):
  - request seen in IDLE at cycle N → `m_req` at N+1 → `rvalid` at N+2;
  - the next transaction can be latched at N+3.
- Throughput: at most one transaction per 3 cycles. No request is latched in the cycle `rvalid` is pulsed.
- Simultaneous `if_req` and `d_req` in IDLE: data is served first unless starved; fetch is served on the following arbitration.

## Structure
- Package `mem_arb_pkg`:
  - `state_t` enum {IDLE, WAIT_GNT, WAIT_RESP};
  - `owner_t` enum {OWN_IF, OWN_D};
  - `STREAK_W` = 4.
- One sub-module, `mem_arb_prio`: the combinational winner select plus the streak counter. The FSM, holding registers and response routing stay in `mem_arbiter`.

## Test plan
- **Fetch only:** `if_req` at addr 0x100, memory returns 0x00500093 → `m_req` with `m_addr` = 0x100 one cycle later, `if_rvalid` with `if_rdata` = 0x00500093 two cycles after request, `if_stall` low in that cycle.
- **Contention:** `if_req` (0x200) and `d_req` store (0x1000, `d_be` = 0xF, data 0xDEADBEEF) both high → store issued first with correct payload, `d_rvalid` pulses, then fetch 0x200 issued.
- **Starvation:** STARVE_MAX = 4, `d_req` held continuously with fresh addresses and `if_req` high → exactly 4 data transactions, then 1 fetch, then data resumes.
- **Kill:**
  - `if_kill` during WAIT_GNT (`m_gnt` held low) → `m_req` drops next cycle, no `if_rvalid`;
  - `if_kill` during WAIT_RESP → `m_rvalid` consumed, no `if_rvalid`, `err` stays 0.
- **Backpressure:** `m_gnt` withheld 5 cycles → `m_req` and payload stable all 5 cycles, `d_stall` high until `d_rvalid`.
- **Protocol/reset:**
  - spurious `m_rvalid` in IDLE → `err` = 1 and sticky;
  - `rst` low mid-WAIT_RESP → all outputs 0 immediately;
  - `m_rvalid` after release → `err` = 1.
